// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared sizes, state codes and helpers for the line-memory arbiter.
package mem_arbiter_pkg;

  localparam int CACHE_LINE_SIZE = 8;
  localparam int DEF_ADDR_W      = 32;
  localparam int DEF_LINE_BITS   = CACHE_LINE_SIZE * 8;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_t;

  // A port only competes for mem when it strobes and names an operation.
  function automatic logic port_eligible(input logic strobe, input logic rd, input logic wr);
    return strobe & (rd | wr);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: one line-transfer bus. The requester side is the master, the side that
// serves the line is the slave; the same bus type links each cache to the arbiter and the
// arbiter to mem.
interface mem_arbiter_if
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int LINE_BITS = DEF_LINE_BITS
);
  logic                 strobe;
  logic                 read_signal;
  logic                 write_signal;
  logic [ADDR_W-1:0]    addr;
  logic [LINE_BITS-1:0] i_data;
  logic [LINE_BITS-1:0] o_data;
  logic                 read_complete_signal;
  logic                 write_complete_signal;

  modport master (
    output strobe, read_signal, write_signal, addr, i_data,
    input  o_data, read_complete_signal, write_complete_signal
  );

  modport slave (
    input  strobe, read_signal, write_signal, addr, i_data,
    output o_data, read_complete_signal, write_complete_signal
  );

endinterface

// File: rtl/mem_arbiter_rr_arbiter2.sv
// rr_arbiter2: combinational two-request round-robin picker. A lone request wins outright;
// with both pending, the port that did not win last time gets the grant.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] gnt
);

  // Pick the grant from the request pair and the previous winner.
  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = last_grant ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin arbiter and sequencer in front of the single-ported line
// memory. Port 0 is the I-cache refill path, port 1 the D-cache refill/writeback path. One
// transaction is outstanding at mem; everything driven toward mem or the caches is registered.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int LINE_BITS = DEF_LINE_BITS
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  p0,
  mem_arbiter_if.slave  p1,
  mem_arbiter_if.master mem
);

  arb_state_t           state_q, state_d;
  logic                 last_grant_q, last_grant_d;
  logic                 grant_q, grant_d;
  logic                 is_read_q, is_read_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [LINE_BITS-1:0] wdata_q, wdata_d;
  logic                 mem_strobe_q, mem_strobe_d;
  logic                 mem_read_q, mem_read_d;
  logic                 mem_write_q, mem_write_d;
  logic [1:0]           rd_done_q, rd_done_d;
  logic [1:0]           wr_done_q, wr_done_d;
  logic [LINE_BITS-1:0] p0_rdata_q, p1_rdata_q;
  logic [1:0]           req, gnt;
  logic                 sel_read, op_done, capture_read;

  assign req = {port_eligible(p1.strobe, p1.read_signal, p1.write_signal),
                port_eligible(p0.strobe, p0.read_signal, p0.write_signal)};

  rr_arbiter2 u_rr (
    .req        (req),
    .last_grant (last_grant_q),
    .gnt        (gnt)
  );

  // Read wins over write when a requester raises both.
  assign sel_read     = gnt[1] ? p1.read_signal : p0.read_signal;
  assign op_done      = is_read_q ? mem.read_complete_signal : mem.write_complete_signal;
  assign capture_read = (state_q == ARB_BUSY) && is_read_q && mem.read_complete_signal;

  // Control and request registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ARB_IDLE;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      is_read_q    <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      mem_strobe_q <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      rd_done_q    <= 2'b00;
      wr_done_q    <= 2'b00;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      is_read_q    <= is_read_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      mem_strobe_q <= mem_strobe_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      rd_done_q    <= rd_done_d;
      wr_done_q    <= wr_done_d;
    end
  end

  // Sequencer: grant and capture in IDLE, hold mem in BUSY, pulse completion in RESP.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    is_read_d    = is_read_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    mem_strobe_d = mem_strobe_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    rd_done_d    = 2'b00;
    wr_done_d    = 2'b00;
    case (state_q)
      ARB_IDLE: begin
        if (gnt != 2'b00) begin
          grant_d      = gnt[1];
          last_grant_d = gnt[1];
          is_read_d    = sel_read;
          addr_d       = gnt[1] ? p1.addr : p0.addr;
          wdata_d      = gnt[1] ? p1.i_data : p0.i_data;
          mem_strobe_d = 1'b1;
          mem_read_d   = sel_read;
          mem_write_d  = ~sel_read;
          state_d      = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        if (op_done) begin
          mem_strobe_d       = 1'b0;
          mem_read_d         = 1'b0;
          mem_write_d        = 1'b0;
          rd_done_d[grant_q] = is_read_q;
          wr_done_d[grant_q] = ~is_read_q;
          state_d            = ARB_RESP;
        end
      end
      ARB_RESP: begin
        state_d = ARB_IDLE;
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // Per-port read data holds until that port's next read completes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p0_rdata_q <= '0;
      p1_rdata_q <= '0;
    end else if (capture_read) begin
      if (grant_q) begin
        p1_rdata_q <= mem.o_data;
      end else begin
        p0_rdata_q <= mem.o_data;
      end
    end
  end

  assign mem.strobe                = mem_strobe_q;
  assign mem.read_signal           = mem_read_q;
  assign mem.write_signal          = mem_write_q;
  assign mem.addr                  = addr_q;
  assign mem.i_data                = wdata_q;
  assign p0.o_data                 = p0_rdata_q;
  assign p1.o_data                 = p1_rdata_q;
  assign p0.read_complete_signal   = rd_done_q[0];
  assign p1.read_complete_signal   = rd_done_q[1];
  assign p0.write_complete_signal  = wr_done_q[0];
  assign p1.write_complete_signal  = wr_done_q[1];

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized scoreboard bench for mem_arbiter. Grant order comes from an
// abstract model of the arbitration rule; a mem responder checks each issued request and a
// monitor checks every completion pulse against the queued expectations.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int AW = DEF_ADDR_W;
  localparam int LW = DEF_LINE_BITS;

  typedef struct {
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
    logic [LW-1:0] rdata;
    logic          rd;
    logic          wr;
    logic          bad_first;
    int            port;
  } txn_t;

  typedef struct {
    int            port;
    logic          is_read;
    logic [LW-1:0] data;
  } resp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  mem_arbiter_if p0_bus ();
  mem_arbiter_if p1_bus ();
  mem_arbiter_if mem_bus ();

  mem_arbiter dut (
    .clk (clk),
    .rst (rst),
    .p0  (p0_bus),
    .p1  (p1_bus),
    .mem (mem_bus)
  );

  always #5 clk = ~clk;

  int            total = 0;
  int            bad   = 0;
  txn_t          pq0[$];
  txn_t          pq1[$];
  txn_t          mem_exp[$];
  resp_t         resp_exp[$];
  logic [LW-1:0] last0 = '0;
  logic [LW-1:0] last1 = '0;
  logic          model_last_grant = 1'b1;

  task automatic checkOutput(input string name, input logic [LW-1:0] actual,
                             input logic [LW-1:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  task automatic failNow(input string name, input string what);
    total++;
    bad++;
    $display("[TB] FAIL %s actual=%s", name, what);
  endtask

  function automatic logic [LW-1:0] rand_line();
    return {$urandom, $urandom};
  endfunction

  // Randomly toggle every bench-driven input (used while reset is held).
  task automatic applyStimulus();
    p0_bus.strobe = 1'($urandom);  p0_bus.read_signal = 1'($urandom);
    p0_bus.write_signal = 1'($urandom);  p0_bus.addr = $urandom;  p0_bus.i_data = rand_line();
    p1_bus.strobe = 1'($urandom);  p1_bus.read_signal = 1'($urandom);
    p1_bus.write_signal = 1'($urandom);  p1_bus.addr = $urandom;  p1_bus.i_data = rand_line();
    mem_bus.o_data = rand_line();
    mem_bus.read_complete_signal  = 1'($urandom);
    mem_bus.write_complete_signal = 1'($urandom);
  endtask

  task automatic clearInputs();
    p0_bus.strobe = 0; p0_bus.read_signal = 0; p0_bus.write_signal = 0;
    p0_bus.addr = '0; p0_bus.i_data = '0;
    p1_bus.strobe = 0; p1_bus.read_signal = 0; p1_bus.write_signal = 0;
    p1_bus.addr = '0; p1_bus.i_data = '0;
    mem_bus.o_data = '0; mem_bus.read_complete_signal = 0; mem_bus.write_complete_signal = 0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_mem_strobe"}, mem_bus.strobe, 0);
    checkOutput({tag, "_mem_read"}, mem_bus.read_signal, 0);
    checkOutput({tag, "_mem_write"}, mem_bus.write_signal, 0);
    checkOutput({tag, "_mem_addr"}, mem_bus.addr, 0);
    checkOutput({tag, "_mem_i_data"}, mem_bus.i_data, 0);
    checkOutput({tag, "_p0_o_data"}, p0_bus.o_data, 0);
    checkOutput({tag, "_p1_o_data"}, p1_bus.o_data, 0);
    checkOutput({tag, "_cpl"}, {p1_bus.write_complete_signal, p1_bus.read_complete_signal,
                                p0_bus.write_complete_signal, p0_bus.read_complete_signal}, 0);
  endtask

  task automatic addTxn(input int port, input logic rd, input logic wr, input logic [AW-1:0] addr,
                        input logic [LW-1:0] wdata, input logic [LW-1:0] rdata,
                        input logic bad_first);
    txn_t t;
    t.port = port; t.rd = rd; t.wr = wr; t.addr = addr;
    t.wdata = wdata; t.rdata = rdata; t.bad_first = bad_first;
    if (port == 0) pq0.push_back(t);
    else pq1.push_back(t);
  endtask

  task automatic addRandomTxn(input int port);
    int opsel;
    opsel = $urandom_range(0, 2);
    addTxn(port, opsel != 1, opsel != 0, $urandom, rand_line(), rand_line(),
           $urandom_range(0, 3) == 0);
  endtask

  task automatic drivePort(input int port, input txn_t t);
    if (port == 0) begin
      p0_bus.strobe = 1; p0_bus.read_signal = t.rd; p0_bus.write_signal = t.wr;
      p0_bus.addr = t.addr; p0_bus.i_data = t.wdata;
    end else begin
      p1_bus.strobe = 1; p1_bus.read_signal = t.rd; p1_bus.write_signal = t.wr;
      p1_bus.addr = t.addr; p1_bus.i_data = t.wdata;
    end
  endtask

  // A dropped strobe leaves junk on the other inputs; it must not be picked up.
  task automatic dropPort(input int port);
    if (port == 0) begin
      p0_bus.strobe = 0; p0_bus.read_signal = 1'($urandom); p0_bus.write_signal = 1'($urandom);
      p0_bus.addr = $urandom; p0_bus.i_data = rand_line();
    end else begin
      p1_bus.strobe = 0; p1_bus.read_signal = 1'($urandom); p1_bus.write_signal = 1'($urandom);
      p1_bus.addr = $urandom; p1_bus.i_data = rand_line();
    end
  endtask

  // Requester: present each queued transaction, keep strobe up until its completion pulse,
  // then present the next one straight away (back-to-back) or drop.
  task automatic portDriver(input int port);
    int   n;
    int   cyc;
    logic done;
    txn_t t;
    n = (port == 0) ? pq0.size() : pq1.size();
    for (int i = 0; i < n; i++) begin
      if (port == 0) t = pq0[i];
      else t = pq1[i];
      drivePort(port, t);
      cyc  = 0;
      done = 0;
      while (!done && cyc < 500) begin
        @(negedge clk);
        cyc++;
        done = (port == 0) ? (p0_bus.read_complete_signal | p0_bus.write_complete_signal)
                           : (p1_bus.read_complete_signal | p1_bus.write_complete_signal);
      end
      if (!done) begin
        failNow("port_completion_wait", "timeout");
        break;
      end
    end
    dropPort(port);
  endtask

  // Memory model: check each request as issued, answer after a random latency, sometimes
  // preceded by a completion strobe of the wrong kind.
  task automatic memResponder(input int n);
    int   cyc;
    txn_t t;
    for (int i = 0; i < n; i++) begin
      cyc = 0;
      while (!mem_bus.strobe && cyc < 500) begin
        @(negedge clk);
        cyc++;
      end
      if (!mem_bus.strobe) begin
        failNow("mem_request_wait", "timeout");
        return;
      end
      if (mem_exp.size() == 0) begin
        failNow("mem_request", "unexpected");
        return;
      end
      t = mem_exp.pop_front();
      checkOutput("mem_addr", mem_bus.addr, t.addr);
      checkOutput("mem_read_signal", mem_bus.read_signal, t.rd);
      checkOutput("mem_write_signal", mem_bus.write_signal, !t.rd);
      checkOutput("mem_i_data", mem_bus.i_data, t.wdata);
      if (t.port == 0) begin p0_bus.addr = $urandom; p0_bus.i_data = rand_line(); end
      else begin p1_bus.addr = $urandom; p1_bus.i_data = rand_line(); end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      if (t.bad_first) begin
        mem_bus.o_data = rand_line();
        if (t.rd) mem_bus.write_complete_signal = 1;
        else mem_bus.read_complete_signal = 1;
        @(negedge clk);
        mem_bus.write_complete_signal = 0;
        mem_bus.read_complete_signal  = 0;
        checkOutput("busy_after_wrong_cpl", mem_bus.strobe, 1);
      end
      mem_bus.o_data = t.rd ? t.rdata : rand_line();
      if (t.rd) mem_bus.read_complete_signal = 1;
      else mem_bus.write_complete_signal = 1;
      @(negedge clk);
      mem_bus.read_complete_signal  = 0;
      mem_bus.write_complete_signal = 0;
      mem_bus.o_data = rand_line();
      checkOutput("mem_strobe_resp", mem_bus.strobe, 0);
      checkOutput("mem_ctl_resp", {mem_bus.read_signal, mem_bus.write_signal}, 0);
    end
  endtask

  // Work out the grant order from the round-robin rule, queue expectations, then run.
  task automatic runRound();
    int    c0, c1, i0, i1, g;
    resp_t r;
    c0 = pq0.size(); c1 = pq1.size(); i0 = 0; i1 = 0;
    while (i0 < c0 || i1 < c1) begin
      if (i0 < c0 && i1 < c1) g = model_last_grant ? 0 : 1;
      else if (i0 < c0) g = 0;
      else g = 1;
      model_last_grant = (g == 1);
      if (g == 0) begin
        mem_exp.push_back(pq0[i0]);
        r.is_read = pq0[i0].rd; r.data = pq0[i0].rdata; i0++;
      end else begin
        mem_exp.push_back(pq1[i1]);
        r.is_read = pq1[i1].rd; r.data = pq1[i1].rdata; i1++;
      end
      r.port = g;
      resp_exp.push_back(r);
    end
    @(negedge clk);
    fork
      portDriver(0);
      portDriver(1);
      memResponder(c0 + c1);
    join
    repeat (3) @(negedge clk);
    checkOutput("resp_queue_drained", resp_exp.size(), 0);
    checkOutput("mem_queue_drained", mem_exp.size(), 0);
    checkOutput("mem_idle_after_round", mem_bus.strobe, 0);
    pq0.delete();
    pq1.delete();
    mem_exp.delete();
    resp_exp.delete();
  endtask

  // Monitor: every completion pulse consumes one expected response, in grant order.
  initial begin : monitor
    logic [3:0] pulses;
    resp_t      e;
    forever begin
      @(negedge clk);
      pulses = {p1_bus.write_complete_signal, p1_bus.read_complete_signal,
                p0_bus.write_complete_signal, p0_bus.read_complete_signal};
      if (pulses != 4'b0000) begin
        checkOutput("cpl_onehot", $countones(pulses), 1);
        if (resp_exp.size() == 0) begin
          failNow("unexpected_complete", "pulse");
        end else begin
          e = resp_exp.pop_front();
          checkOutput("cpl_pulses", pulses,
                      {e.port == 1 && !e.is_read, e.port == 1 && e.is_read,
                       e.port == 0 && !e.is_read, e.port == 0 && e.is_read});
          if (e.is_read) begin
            if (e.port == 0) last0 = e.data;
            else last1 = e.data;
          end
          checkOutput("p0_o_data", p0_bus.o_data, last0);
          checkOutput("p1_o_data", p1_bus.o_data, last1);
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    bad++;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    int cyc;
    clearInputs();
    rst = 0;

    // Reset held with inputs toggling: every output stays 0.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkAllZero("reset");
      applyStimulus();
    end
    @(negedge clk);
    clearInputs();
    @(negedge clk);
    rst = 1;
    repeat (5) begin
      @(negedge clk);
      checkOutput("idle_no_strobe", mem_bus.strobe, 0);
    end

    // Single read on p0, single write on p1.
    addTxn(0, 1, 0, 32'h40, rand_line(), 64'hA5A5_A5A5_A5A5_A5A5, 0);
    runRound();
    addTxn(1, 0, 1, 32'h80, 64'h1234_5678_9ABC_DEF0, rand_line(), 0);
    runRound();

    // Contention held high: grants alternate p0,p1,p0,p1.
    for (int i = 0; i < 2; i++) begin
      addTxn(0, 1, 0, 32'h100 + i, rand_line(), rand_line(), 0);
      addTxn(1, 1, 0, 32'h200 + i, rand_line(), rand_line(), 0);
    end
    runRound();

    // Wrong-kind completion is ignored; read=write=1 is a read.
    addTxn(0, 1, 0, 32'h300, rand_line(), rand_line(), 1);
    addTxn(1, 1, 1, 32'h340, rand_line(), rand_line(), 1);
    addTxn(1, 0, 1, 32'h380, rand_line(), rand_line(), 1);
    runRound();

    // Randomized rounds, with stray mem completions while idle in between.
    for (int r = 0; r < 30; r++) begin
      for (int k = $urandom_range(0, 3); k > 0; k--) addRandomTxn(0);
      for (int k = $urandom_range(0, 3); k > 0; k--) addRandomTxn(1);
      runRound();
      mem_bus.o_data = rand_line();
      mem_bus.read_complete_signal  = 1'($urandom);
      mem_bus.write_complete_signal = 1'($urandom);
      @(negedge clk);
      mem_bus.read_complete_signal  = 0;
      mem_bus.write_complete_signal = 0;
      repeat (2) @(negedge clk);
      checkOutput("stray_cpl_p0_o_data", p0_bus.o_data, last0);
      checkOutput("stray_cpl_p1_o_data", p1_bus.o_data, last1);
      checkOutput("stray_cpl_no_strobe", mem_bus.strobe, 0);
    end

    // Reset while BUSY: mem released at once, no completion pulse.
    p0_bus.strobe = 1; p0_bus.read_signal = 1; p0_bus.write_signal = 0;
    p0_bus.addr = 32'h500; p0_bus.i_data = rand_line();
    cyc = 0;
    while (!mem_bus.strobe && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    if (!mem_bus.strobe) failNow("midop_grant_wait", "timeout");
    @(negedge clk);
    rst = 0;
    #1;
    checkAllZero("midop_reset");
    p0_bus.strobe = 0;
    last0 = '0;
    last1 = '0;
    model_last_grant = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1;
    repeat (4) @(negedge clk);
    checkOutput("post_reset_idle", mem_bus.strobe, 0);
    addTxn(1, 0, 1, 32'h600, rand_line(), rand_line(), 0);
    addTxn(1, 1, 0, 32'h640, rand_line(), rand_line(), 0);
    runRound();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
